muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Sequencer between the EX stage and the shared iterative multiplier/divider units.
- Accepts one mult/multu/div/divu per instruction and latches its operands.
- Drives start/annul/signed to the selected unit and raises the EX stall request until the result is ready.
- Holds the 64-bit result until the pipeline advances, then issues a single-cycle HI/LO write.
- Handles divide-by-zero, flush and a watchdog timeout.

Parameters:
TIMEOUT, 64, max cycles in a RUN state before the watchdog fires (must be < 256)
CNT_W, 8, width of the busy-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  kill in-flight op, no HI/LO write
op_valid  in  1  EX holds a mul/div instruction; stays stable while stallreq=1
op_code  in  2  00 mult, 01 multu, 10 div, 11 divu
src_a  in  32  rs operand
src_b  in  32  rt operand
stall_in  in  1  downstream stall; EX cannot advance this cycle
mul_start  out  1  level start to multiplier
mul_signed  out  1  signed multiply
mul_a  out  32  multiplier operand A
mul_b  out  32  multiplier operand B
mul_annul  out  1  abort multiplier
mul_ready  in  1  multiplier result valid
mul_result  in  64  {hi,lo} product
div_start  out  1  level start to divider
div_signed  out  1  signed divide
div_a  out  32  dividend
div_b  out  32  divisor
div_annul  out  1  abort divider
div_ready  in  1  divider result valid
div_result  in  64  {remainder,quotient}
stallreq  out  1  stall request to the stall controller
hi_we  out  1  HI write enable
lo_we  out  1  LO write enable
hi_wdata  out  32  HI value
lo_wdata  out  32  LO value
busy_cnt  out  CNT_W  cycles spent in the current or last op
wdog_err  out  1  sticky watchdog flag

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- Reset value: all outputs 0, state IDLE. Reset mid-operation returns to IDLE with no annul and no write.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE:
  - On op_valid & ~flush, latch op_code, src_a, src_b and clear busy_cnt.
  - op_code 0x goes to MUL_RUN. 1x with src_b!=0 goes to DIV_RUN. 1x with src_b==0 goes to DONE with result {hi=src_a, lo=32'hFFFF_FFFF} and never starts the divider.
- stallreq = (IDLE & op_valid & ~flush) | MUL_RUN | DIV_RUN. It is combinational, so the accept cycle already stalls.
- MUL_RUN / DIV_RUN:
  - Selected unit sees start=1 with operands from the latched registers. signed = ~op_code[0].
  - Non-selected unit outputs are 0.
  - busy_cnt increments each cycle and saturates at all-ones.
  - On ready=1: capture the 64-bit result, go to DONE, drop start the same cycle.
  - Earliest DONE is 2 cycles after accept with a 1-cycle unit.
- DONE:
  - stallreq=0.
  - If ~stall_in: hi_we=lo_we=1 for exactly that cycle, with hi_wdata/lo_wdata = captured {hi,lo}, then go to IDLE.
  - If stall_in: hold the result, keep we=0, stay in DONE.
  - Write data is valid only while we=1; otherwise it is 0.
- Flush in any state:
  - Next state IDLE, no we.
  - If flushed in a RUN state, the active unit's annul=1 for that cycle and start=0.
  - Flush beats ready in the same cycle. Flush beats the DONE write.
- Back-to-back ops: from DONE→IDLE, a new op_valid is accepted on the following cycle (1 idle bubble). EX is guaranteed to present the next instruction only after advancing.
- Watchdog:
  - When busy_cnt reaches TIMEOUT in a RUN state, set wdog_err (sticky until rst), annul the unit and go to IDLE.
  - stallreq drops and no write occurs.
- Ready arriving while IDLE or DONE is ignored.

Decomposition:
- Shared defines header: op_code encodings, state encodings, DIVZERO_LO = 32'hFFFF_FFFF; reuse existing Stop/NoStop and start/ready macros.
- No sub-module needed. An optional small result-hold register block (muldiv_res_hold) may be split out; default is a single module.

Test Plan:
- multu 0xFFFF_FFFF × 2, unit ready after 3 cycles, stall_in=0 → stallreq high 4 cycles; one-cycle hi_we/lo_we with hi=0x0000_0001, lo=0xFFFF_FFFE; busy_cnt=3.
- div 0xFFFF_FFF9 (-7) / 2, signed → div_signed=1, div_a/b held stable until ready; write hi=0xFFFF_FFFF, lo=0xFFFF_FFFD.
- divu 5 / 0 → div_start never asserts; DONE next cycle; hi=5, lo=0xFFFF_FFFF.
- mult done with stall_in=1 for 3 cycles → we stays 0, data held; we=1 on the first cycle stall_in=0, exactly once.
- flush on the same cycle as mul_ready → mul_annul=1, no write, IDLE next; a following mult completes normally.
- unit never returns ready, TIMEOUT=64 → wdog_err=1 at busy_cnt=64, annul pulse, stallreq=0 next cycle, wdog_err stays 1 until rst.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the mul/div sequencer: op codes, FSM states and the
// fixed LO value written on a divide by zero.
package muldiv_ctrl_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the shared iterative multiplier/divider.
// Latches one op, runs the selected unit with a level start, holds the
// 64-bit result until EX can advance, then issues a one-cycle HI/LO write.
// Flush and a watchdog abort the unit via annul; divide by zero bypasses
// the divider entirely.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [31:0]      src_a,
  input  logic [31:0]      src_b,
  input  logic             stall_in,
  output logic             mul_start,
  output logic             mul_signed,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_annul,
  input  logic             mul_ready,
  input  logic [63:0]      mul_result,
  output logic             div_start,
  output logic             div_signed,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  output logic             div_annul,
  input  logic             div_ready,
  input  logic [63:0]      div_result,
  output logic             stallreq,
  output logic             hi_we,
  output logic             lo_we,
  output logic [31:0]      hi_wdata,
  output logic [31:0]      lo_wdata,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             wdog_err
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [63:0]      res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             wdog_q;

  logic accept, run, wdog_hit, abort, unit_ready;

  assign busy_cnt = cnt_q;
  assign wdog_err = wdog_q;

  // Next state plus all unit/pipeline handshakes; everything is forced
  // quiet while rst is high so a reset mid-op never annuls or writes.
  always_comb begin
    accept     = (state_q == ST_IDLE) && op_valid && !flush;
    run        = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
    wdog_hit   = run && (cnt_q == TO_CNT);
    abort      = flush || wdog_hit;
    unit_ready = (state_q == ST_MUL_RUN) ? mul_ready : div_ready;
    state_d    = state_q;
    mul_start  = 1'b0;
    mul_signed = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    mul_annul  = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_annul  = 1'b0;
    stallreq   = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_div(op_code))  state_d = ST_MUL_RUN;
          else if (src_b != '0) state_d = ST_DIV_RUN;
          else                  state_d = ST_DONE;
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        if (abort)           state_d = ST_IDLE;
        else if (unit_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (flush || !stall_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst) begin
      stallreq = accept || run;
      if (state_q == ST_MUL_RUN) begin
        mul_signed = is_signed(op_q);
        mul_a      = a_q;
        mul_b      = b_q;
        mul_annul  = abort;
        mul_start  = !abort && !mul_ready;
      end
      if (state_q == ST_DIV_RUN) begin
        div_signed = is_signed(op_q);
        div_a      = a_q;
        div_b      = b_q;
        div_annul  = abort;
        div_start  = !abort && !div_ready;
      end
      if (state_q == ST_DONE && !stall_in && !flush) begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        hi_wdata = res_q[63:32];
        lo_wdata = res_q[31:0];
      end
    end
  end

  // State, operand latch, result capture, busy counter and sticky watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      wdog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_code;
        a_q   <= src_a;
        b_q   <= src_b;
        cnt_q <= '0;
        if (is_div(op_code) && src_b == '0) res_q <= {src_a, DIVZERO_LO};
      end
      if (run) begin
        if (wdog_hit && !flush)  wdog_q <= 1'b1;
        else if (cnt_q != '1)    cnt_q  <= cnt_q + 1'b1;
        if (!abort && unit_ready)
          res_q <= (state_q == ST_MUL_RUN) ? mul_result : div_result;
      end
    end
  end

endmodule
